// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ / IDX_W : requester count and index width
//   state_t       : arbiter FSM states
//   rr_pick()     : one-hot pick of the first request after last_idx, with wrap
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Scan starts one past the previous winner, so that requester ends up
  // with the lowest priority this round. Returns 0 when nothing is requested.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last_idx);
    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pos;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = last_idx + IDX_W'(k);
      if (!found && req[pos]) begin
        pick[pos] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/onehot_enc8.sv
// 8-to-3 one-hot encoder.
//   onehot : input vector
//   code   : index of the set bit; 3'd0 when the input is not one-hot
//   valid  : high when exactly one bit is set
module onehot_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] code,
  output logic             valid
);

  logic [IDX_W-1:0] code_raw;

  // Exactly-one test: nonzero and clearing the lowest set bit leaves zero.
  assign valid = (onehot != '0) && ((onehot & (onehot - N_REQ'(1))) == '0);

  always_comb begin
    code_raw = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) code_raw = code_raw | IDX_W'(i);
    end
  end

  assign code = valid ? code_raw : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: one shared resource, 8 requesters, registered one-hot
// grant plus its binary index (used as the datapath operand-mux select).
//   clk, rst_n  : clock, async active-low reset
//   req[7:0]    : request vector, held high while a requester needs the resource
//   gnt[7:0]    : registered one-hot grant, 0 when idle
//   gnt_code    : binary index of gnt, 0 when gnt_valid=0
//   gnt_valid   : gnt != 0
//   timeout     : one-cycle pulse when a grant is forcibly revoked
// Optional build macro ARB_TIMEOUT_EN enables the MAX_HOLD grant limit;
// without it a grant is held for as long as its request stays high.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | nothing granted; pick the next requester after last_idx
// BUSY  | gnt holds one requester until it drops req (or hold expires)
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_code,
  output logic             gnt_valid,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter8: MAX_HOLD must lie in 2..255");
  end

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             timeout_q, timeout_d;

  onehot_enc8 u_enc (
    .onehot (gnt_q),
    .code   (gnt_code),
    .valid  (gnt_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  // gnt_code is the live index in BUSY since gnt is one-hot there.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          gnt_d   = rr_pick(req, last_q);
          state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (!req[gnt_code]) begin
          gnt_d   = '0;
          last_d  = gnt_code;
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          gnt_d     = '0;
          last_d    = gnt_code;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign timeout = timeout_q;

endmodule
